regfile_bypass: RTL and testbench
=================================

# regfile_bypass

Parametrised, single-clock register file for the in-order RV32I pipeline. It replaces the double-clocked register file: all read and write ports run on the pipeline clock. It adds write-first internal bypass and a per-register scoreboard so that issue logic can stall on pending multi-cycle results such as loads. It sits between decode (read ports, reserve port) and writeback (write ports).

## Interface
Parameters:
- XLEN, 32, register data width
- NREGS, 32, number of architectural registers (power of two, ≥2); AW = clog2(NREGS)
- NRD, 2, number of read ports (1..4)
- NWR, 1, number of write ports (1..2)
- ZERO_REG, 1, when 1 register 0 reads as 0, ignores writes, is never busy

Ports:
- clk  in  1  pipeline clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- rd_en  in  NRD  per-port read enable
- rd_addr  in  NRD*AW  read addresses, port i at [i*AW +: AW]
- rd_data  out  NRD*XLEN  registered read data, 1-cycle latency
- rd_busy  out  NRD  combinational: addressed register has a pending producer
- wr_en  in  NWR  per-port write enable
- wr_addr  in  NWR*AW  write addresses
- wr_data  in  NWR*XLEN  write data
- rsv_en  in  1  reserve: mark rsv_addr busy (producer issued)
- rsv_addr  in  AW  register to reserve
- busy_any  out  1  OR of all busy bits (drain/debug)

Reset: async, active-high on rst. Clock is clk.

## Operation
- Storage: NREGS x XLEN flops, plus NREGS busy bits.
- Write: on the edge with wr_en[j]=1, reg[wr_addr[j]] <= wr_data[j].
  - Two write ports targeting the same address in the same cycle: the higher index j wins.
  - ZERO_REG=1 and address 0: the write is dropped.
- Read: on the edge with rd_en[i]=1, rd_data[i] <= value of reg[rd_addr[i]] after this cycle's writes (write-first bypass).
  - Bypass applies the same priority as storage (highest j).
  - rd_en[i]=0: rd_data[i] holds its previous value.
  - Address 0 with ZERO_REG=1 returns 0.
- Scoreboard:
  - rsv_en sets busy[rsv_addr].
  - Any wr_en[j] clears busy[wr_addr[j]].
  - Same-cycle reserve and write to the same register: reserve wins and busy stays 1 (new producer overtakes the retiring one).
  - ZERO_REG=1: busy[0] is constant 0; reserve of register 0 is ignored.
- rd_busy[i] = busy[rd_addr[i]] AND NOT (some wr_en[j] with wr_addr[j]==rd_addr[i] this cycle). A result retiring this cycle is therefore visible through the bypass, and issue need not stall.
- Reserving an already-busy register is legal and leaves it busy. Writing a non-busy register is legal and does not affect the scoreboard.

## Timing
- Read latency: 1 cycle. Address is presented in cycle N; data is valid after edge N, throughout cycle N+1.
- Write-to-read: a write in cycle N is visible to a read issued in cycle N (bypass), not N+1.
- rd_busy and busy_any are combinational from the addresses and current state; there is no registered stall.
- Reset, asserted at any time including mid-operation:
  - All registers become 0.
  - All busy bits become 0.
  - rd_data becomes 0; rd_busy and busy_any become 0.
  - Inputs are ignored while rst is high.
  - The first edge after deassertion samples normally.

## Structure
- Shared package `rv_pkg` holds XLEN default, register-index width constant, and the x0 index constant. The decoder and ALU use the same package.
- One sub-module: `regfile_scoreboard` (busy bits, reserve/clear priority, rd_busy/busy_any generation), parametrised on NREGS, NRD, NWR, ZERO_REG.
- Read and write ports are generate loops in the top module.

## Test plan
- Reset then read all: rst=1 mid-stream, release, read regs 0..31 on both ports -> all 0, rd_busy=0, busy_any=0.
- Write-first bypass: cycle N write x5=0xDEADBEEF while port 0 reads x5 -> rd_data[0]=0xDEADBEEF in cycle N+1. Port 1 reading x5 one cycle later also returns 0xDEADBEEF.
- Zero register: write x0=0x1234 and reserve x0, then read x0 -> data 0, rd_busy=0. With ZERO_REG=0, the same sequence -> data 0x1234.
- Scoreboard:
  - Reserve x7, then read x7 -> rd_busy=1 until the write.
  - Write x7=0x55 with a same-cycle read -> rd_busy=0 in that cycle, data 0x55 next cycle.
- Simultaneous events:
  - NWR=2: both ports write x3 (0x11 on j=0, 0x22 on j=1) -> read x3 returns 0x22.
  - Same-cycle rsv_en x3 and wr_en x3 -> busy[x3] stays 1.
- Hold and mid-operation reset:
  - rd_en=0 for 3 cycles after reading 0xA5 -> rd_data holds 0xA5.
  - Assert rst asynchronously between edges -> rd_data=0 immediately.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV32I constants: default data width, register-index width, x0 index.
package rv_pkg;
  localparam int XLEN_DEF = 32;
  localparam int REG_AW   = 5;
  localparam logic [REG_AW-1:0] X0_IDX = '0;
endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: reserve sets, writeback clears, reserve wins on collision.
module regfile_scoreboard
  import rv_pkg::*;
#(
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int NWR      = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRD*AW-1:0] rd_addr,
  input  logic [NWR-1:0]    wr_en,
  input  logic [NWR*AW-1:0] wr_addr,
  input  logic              rsv_en,
  input  logic [AW-1:0]     rsv_addr,
  output logic [NRD-1:0]    rd_busy,
  output logic              busy_any
);
  logic [NREGS-1:0] busy, busy_nxt, set_m, clr_m;

  always_comb begin
    clr_m = '0;
    for (int j = 0; j < NWR; j++)
      if (wr_en[j]) clr_m[wr_addr[j*AW +: AW]] = 1'b1;
    set_m = '0;
    if (rsv_en) set_m[rsv_addr] = 1'b1;
    // set applied after clear: a new producer overtakes the retiring one
    busy_nxt = (busy & ~clr_m) | set_m;
    if (ZERO_REG != 0) busy_nxt[AW'(X0_IDX)] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) busy <= '0;
    else     busy <= busy_nxt;

  // a result retiring this cycle is visible via bypass, so it never stalls
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [NWR-1:0] hit;
    for (genvar j = 0; j < NWR; j++) begin : g_hit
      assign hit[j] = wr_en[j] && (wr_addr[j*AW +: AW] == rd_addr[i*AW +: AW]);
    end
    assign rd_busy[i] = busy[rd_addr[i*AW +: AW]] & ~(|hit);
  end

  assign busy_any = |busy;
endmodule

// File: rtl/regfile_bypass.sv
// Single-clock register file with write-first read bypass and issue scoreboard.
module regfile_bypass
  import rv_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREGS    = 2**REG_AW,
  parameter int NRD      = 2,
  parameter int NWR      = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD-1:0]      rd_en,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_addr,
  output logic                busy_any
);
  logic [NREGS-1:0][XLEN-1:0] regs, nxt;
  logic [NWR-1:0][NREGS-1:0]  wr_dec;

  // one-hot write decode per port; x0 writes vanish here when hardwired
  for (genvar j = 0; j < NWR; j++) begin : g_wr
    logic [AW-1:0] wa;
    assign wa = wr_addr[j*AW +: AW];
    assign wr_dec[j] = (wr_en[j] && !(ZERO_REG != 0 && wa == AW'(X0_IDX)))
                       ? (NREGS'(1) << wa) : '0;
  end

  // later ports overwrite earlier ones: highest index wins
  always_comb begin
    nxt = regs;
    for (int j = 0; j < NWR; j++)
      for (int r = 0; r < NREGS; r++)
        if (wr_dec[j][r]) nxt[r] = wr_data[j*XLEN +: XLEN];
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) regs <= '0;
    else     regs <= nxt;

  // reads sample post-write state, giving write-first bypass for free
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [XLEN-1:0] q;
    always_ff @(posedge clk or posedge rst)
      if (rst)           q <= '0;
      else if (rd_en[i]) q <= nxt[rd_addr[i*AW +: AW]];
    assign rd_data[i*XLEN +: XLEN] = q;
  end

  regfile_scoreboard #(
    .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .ZERO_REG(ZERO_REG)
  ) u_sb (
    .clk(clk), .rst(rst),
    .rd_addr(rd_addr),
    .wr_en(wr_en), .wr_addr(wr_addr),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .rd_busy(rd_busy), .busy_any(busy_any)
  );
endmodule

// File: tb/tb_regfile_bypass.sv
// Directed bench: read expectations are queued at issue, checked by a monitor.
module tb_regfile_bypass;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  rd_en;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data, rd_data_nz;
  logic [1:0]  rd_busy, rd_busy_nz;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        rsv_en;
  logic [4:0]  rsv_addr;
  logic        busy_any, busy_any_nz;

  int checks = 0;
  int errors = 0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [1:0]  vld;

  always #5 clk = ~clk;

  regfile_bypass #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .ZERO_REG(1)) u_dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_any(busy_any)
  );

  regfile_bypass #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .ZERO_REG(0)) u_dut_nz (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_nz),
    .rd_busy(rd_busy_nz), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_any(busy_any_nz)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] re, input logic [4:0] ra0, input logic [4:0] ra1,
                       input logic [1:0] we, input logic [4:0] wa0, input logic [31:0] wd0,
                       input logic [4:0] wa1, input logic [31:0] wd1,
                       input logic rs, input logic [4:0] rsa,
                       input logic [31:0] e0, input logic [31:0] e1);
    rd_en = re; rd_addr = {ra1, ra0};
    wr_en = we; wr_addr = {wa1, wa0}; wr_data = {wd1, wd0};
    rsv_en = rs; rsv_addr = rsa;
    if (re[0]) q0.push_back(e0);
    if (re[1]) q1.push_back(e1);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // read-issue valid pipe: data for a read issued before edge N is checked after it
  always @(posedge clk or posedge rst)
    if (rst) vld <= 2'b00;
    else     vld <= rd_en;

  always @(negedge clk) begin
    if (vld[0]) begin
      if (q0.size() == 0) chk("q0_underflow", 32'd1, 32'd0);
      else chk("rd_data0", rd_data[31:0], q0.pop_front());
    end
    if (vld[1]) begin
      if (q1.size() == 0) chk("q1_underflow", 32'd1, 32'd0);
      else chk("rd_data1", rd_data[63:32], q1.pop_front());
    end
  end

  initial begin
    rst = 1'b1;
    drive(0,0,0, 0,0,0,0,0, 0,0, 0,0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // dirty some state, then reset mid-stream
    drive(0,0,0, 2'b01,9,32'h99,0,0, 1,4, 0,0); tick();
    drive(0,0,0, 0,0,0,0,0, 0,0, 0,0);
    chk("pre_rst_busy_any", busy_any, 1);
    #2 rst = 1'b1;
    #1 chk("rst_busy_any", busy_any, 0);
    chk("rst_rd_data", rd_data[31:0] | rd_data[63:32], 0);
    tick(); tick();
    rst = 1'b0;
    tick();

    for (int r = 0; r < 32; r++) begin
      drive(2'b11, 5'(r), 5'(31-r), 0,0,0,0,0, 0,0, 0,0);
      #1 chk("rstall_rd_busy", rd_busy, 0);
      tick();
    end
    drive(0,0,0, 0,0,0,0,0, 0,0, 0,0); tick();
    chk("rstall_busy_any", busy_any, 0);

    // write-first bypass
    drive(2'b01,5,0, 2'b01,5,32'hDEADBEEF,0,0, 0,0, 32'hDEADBEEF,0); tick();
    drive(2'b10,0,5, 0,0,0,0,0, 0,0, 0,32'hDEADBEEF); tick();

    // zero register: write + reserve x0, then read
    drive(0,0,0, 2'b01,0,32'h1234,0,0, 1,0, 0,0); tick();
    drive(2'b11,0,0, 0,0,0,0,0, 0,0, 0,0);
    #1 chk("x0_rd_busy", rd_busy, 0);
    chk("x0_busy_any", busy_any, 0);
    chk("nz_x0_rd_busy", rd_busy_nz, 2'b11);
    chk("nz_x0_busy_any", busy_any_nz, 1);
    tick();
    chk("nz_x0_data0", rd_data_nz[31:0], 32'h1234);
    chk("nz_x0_data1", rd_data_nz[63:32], 32'h1234);
    drive(0,0,0, 2'b01,0,32'h0,0,0, 0,0, 0,0); tick();
    drive(0,0,0, 0,0,0,0,0, 0,0, 0,0);
    #1 chk("nz_x0_cleared", busy_any_nz, 0);

    // scoreboard stall on x7 until writeback
    drive(0,0,0, 0,0,0,0,0, 1,7, 0,0); tick();
    drive(2'b01,7,0, 0,0,0,0,0, 0,0, 0,0);
    #1 chk("x7_busy_p0", rd_busy[0], 1);
    chk("x7_busy_any", busy_any, 1);
    tick();
    drive(2'b10,0,7, 0,0,0,0,0, 0,0, 0,0);
    #1 chk("x7_busy_p1", rd_busy[1], 1);
    tick();
    drive(2'b01,7,0, 2'b01,7,32'h55,0,0, 0,0, 32'h55,0);
    #1 chk("x7_retire_rd_busy", rd_busy[0], 0);
    chk("x7_retire_busy_any", busy_any, 1);
    tick();
    drive(0,0,0, 0,0,0,0,0, 0,0, 0,0);
    #1 chk("x7_cleared", busy_any, 0);

    // two writers on x3: port 1 wins, bypass and storage
    drive(2'b01,3,0, 2'b11,3,32'h11,3,32'h22, 0,0, 32'h22,0); tick();
    drive(2'b10,0,3, 0,0,0,0,0, 0,0, 0,32'h22); tick();
    // same-cycle reserve and write: stays busy
    drive(0,0,0, 2'b01,3,32'h33,0,0, 1,3, 0,0); tick();
    drive(2'b01,3,0, 0,0,0,0,0, 0,0, 32'h33,0);
    #1 chk("rsv_wins_rd_busy", rd_busy[0], 1);
    chk("rsv_wins_busy_any", busy_any, 1);
    tick();
    drive(0,0,0, 2'b01,3,32'h44,0,0, 0,0, 0,0); tick();
    drive(0,0,0, 0,0,0,0,0, 0,0, 0,0);
    #1 chk("x3_cleared", busy_any, 0);

    // hold with rd_en low, then async reset between edges
    drive(2'b01,10,0, 2'b01,10,32'hA5,0,0, 0,0, 32'hA5,0); tick();
    for (int k = 0; k < 3; k++) begin
      drive(0,0,0, 0,0,0,0,0, (k == 0),12, 0,0); tick();
      chk("hold_a5", rd_data[31:0], 32'hA5);
    end
    chk("x12_busy_any", busy_any, 1);
    #3 rst = 1'b1;
    #1 chk("midrst_rd_data", rd_data[31:0], 0);
    chk("midrst_busy_any", busy_any, 0);
    chk("midrst_rd_busy", rd_busy, 0);
    #1 rst = 1'b0;
    tick();
    drive(2'b01,10,0, 0,0,0,0,0, 0,0, 0,0);
    #1 chk("post_rst_x10_busy", rd_busy[0], 0);
    tick();
    drive(2'b10,0,12, 0,0,0,0,0, 0,0, 0,0);
    #1 chk("post_rst_x12_busy", rd_busy[1], 0);
    tick();
    drive(0,0,0, 0,0,0,0,0, 0,0, 0,0);
    tick(); tick();
    chk("queue_drain", 32'(q0.size() + q1.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
